priority_encoder_stream: RTL
============================

# priority_encoder_stream

Parametrised, sequential successor to the 4x2 priority encoder. Accepts an N-bit request vector over a valid/ready handshake and emits the index of every set bit, one per output beat, highest index first. Each bit is cleared as it is reported. Used wherever a multi-hot vector (interrupt pending, error flags, free-slot map) must be serialised into encoded indices for a downstream consumer that can stall.

## Interface

Parameters:
- `N`, default 8: request vector width; legal range 2..64.
- `W`, default `$clog2(N)`: index width; localparam, not overridable.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `e`  input  1  active-high enable; when 0 the block freezes (see Operation).
- `in_valid`  input  1  request vector `x` is valid.
- `in_ready`  output  1  block can accept `x`.
- `x`  input  N  request vector; bit i set means index i is pending.
- `out_valid`  output  1  `y`, `none` and `last` are valid.
- `out_ready`  input  1  consumer accepts the current beat.
- `y`  output  W  encoded index of the highest pending bit.
- `none`  output  1  beat reports an all-zero input vector.
- `last`  output  1  final beat for the current vector.

## Operation

Registers:
- `pending[N-1:0]`
- `state` ∈ {IDLE, DRAIN}
- `zero_flag`

Reset (async, any time, including mid-drain):
- `state`=IDLE, `pending`=0, `zero_flag`=0.
- Hence `out_valid`=0, `y`=0, `none`=0, `last`=0 and `in_ready`=`e`.

IDLE:
- `in_ready` = `e`.
- On `in_valid && in_ready`:
  - `pending` <= `x`
  - `zero_flag` <= (`x`==0)
  - `state` <= DRAIN

DRAIN:
- `in_ready` = 0.
- `out_valid` = `e`.
- `y` = index of the highest set bit of `pending`; `y` = 0 when `zero_flag`.
- `none` = `zero_flag`.
- `last` = 1 when `pending` has exactly one bit set, or when `zero_flag`.
- On `out_valid && out_ready`:
  - If `last`: `pending` <= 0, `zero_flag` <= 0, `state` <= IDLE.
  - Otherwise: clear bit `y` of `pending` and stay in DRAIN.

Enable:
- `e`=0 holds all state.
- `in_ready` and `out_valid` are forced to 0, so no handshake completes.
- Draining resumes unchanged when `e` returns to 1.

Rules:
- `y`, `none` and `last` are stable while `out_valid`=1 and `out_ready`=0.
- `x` is sampled only on the accepting edge; later changes to `x` are ignored.
- No overlap between vectors: a new vector is accepted at the earliest on the cycle after the `last` handshake.
- `y` is zero-extended logic; no X is ever driven. This replaces the 2'bxx output of the 4x2 encoder.

## Timing

Latency and throughput:
- Accept edge to first `out_valid`: 1 cycle.
- One beat per cycle while `out_ready`=1.
- A vector with k set bits occupies k output cycles, plus 1 return cycle before `in_ready` reasserts.
- An all-zero vector takes 1 accept cycle + 1 beat + 1 return cycle.

Combinational paths:
- `in_ready` and `out_valid` depend combinationally on `state` and `e` only.
- There is no combinational path from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`.
- `y` and `last` come from the `pending` register through the priority and one-hot-detect logic. There is no input-to-output combinational path.

Reset:
- Takes effect immediately (asynchronous).
- Release is synchronised externally.

## Configuration

- Macro: `PRIO_ENC_LSB_FIRST_EN`.
- Undefined (default): indices are reported highest first, matching the 4x2 encoder priority (bit N-1 wins).
- Defined: indices are reported lowest first; `y` = index of the lowest set bit of `pending`.
- All other behaviour is identical in both builds, including handshake, `last`, `none` and enable.

## Test plan

All scenarios use N=8.

- **Reset state:** assert `rst` with `e`=1 → `out_valid`=0, `y`=0, `in_ready`=1. Assert `rst` mid-drain → `out_valid` drops immediately; after release `in_ready`=1 and no stale beat appears.
- **Basic drain:** `x`=8'b1010_0100, `out_ready`=1 → beats `y`=7,5,2 on three consecutive cycles. `last`=1 only with `y`=2. `in_ready`=1 one cycle after the `last` handshake. With `PRIO_ENC_LSB_FIRST_EN` defined → `y`=2,5,7.
- **Backpressure:** `x`=8'h81, `out_ready`=0 for 3 cycles → `y`=7 and `last`=0 held stable. Then `out_ready`=1 → `y`=7, then `y`=0 with `last`=1.
- **Zero vector:** `x`=0 → a single beat with `none`=1, `y`=0, `last`=1, then return to IDLE.
- **Enable gating:** `x`=8'hFF, drop `e` after 2 beats (`y`=7,6) for 4 cycles → `out_valid`=0 and `in_ready`=0 throughout. Restore `e` → `y`=5,4,3,2,1,0.
- **Input isolation:** change `x` and hold `in_valid`=1 during DRAIN → the new vector is not accepted until `in_ready` reasserts, and the beats reflect only the originally sampled vector.

Source files
------------

// File: rtl/priority_encoder_stream.sv
// Serialises an N-bit multi-hot request vector into one encoded index per output beat.
// Optional build macro PRIO_ENC_LSB_FIRST_EN reports lowest index first instead of highest.
module priority_encoder_stream #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         e,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic         none,
  output logic         last
);

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_t       state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic         zero_q, zero_d;

  logic [W-1:0] sel_idx;
  logic         one_hot;

  // Priority select: later loop iterations override earlier ones, so the scan order sets the winner.
  always_comb begin
    sel_idx = '0;
`ifdef PRIO_ENC_LSB_FIRST_EN
    for (int i = N - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        sel_idx = i[W-1:0];
      end
    end
`else
    for (int i = 0; i < N; i++) begin
      if (pending_q[i]) begin
        sel_idx = i[W-1:0];
      end
    end
`endif
  end

  assign one_hot = (pending_q != '0) && ((pending_q & (pending_q - ONE)) == '0);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    zero_d    = zero_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    y         = '0;
    none      = 1'b0;
    last      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = e;
        if (in_valid && e) begin
          pending_d = x;
          zero_d    = (x == '0);
          state_d   = DRAIN;
        end else begin
          state_d   = IDLE;
        end
      end
      DRAIN: begin
        out_valid = e;
        y         = zero_q ? '0 : sel_idx;
        none      = zero_q;
        last      = one_hot || zero_q;
        if (e && out_ready) begin
          if (last) begin
            pending_d = '0;
            zero_d    = 1'b0;
            state_d   = IDLE;
          end else begin
            // Retire the bit just reported; the next beat picks the following index.
            pending_d = pending_q & ~(ONE << sel_idx);
          end
        end else begin
          state_d   = DRAIN;
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = '0;
        zero_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      zero_q    <= zero_d;
    end
  end

endmodule
